mem_seq_master: RTL and testbench
=================================

# mem_seq_master

Synchronous request initiator for the single-port `memory` block's valid/ready interface. It replaces the hand-written bench tasks with synthesizable sequencing:
- writes a deterministic data pattern over an address window;
- reads the window back, compares each word and reports errors.

It sits between a control register/bench and the memory's `valid`/`wr_rd`/`addr`/`wdata`/`rdata`/`ready` port.

## Interface
- `WIDTH`, 8, data width; must match the memory.
- `DEPTH`, 32, memory depth in words.
- `ADDR_WIDTH`, $clog2(DEPTH), address width.
- `clk`  in  1  clock; all logic on rising edge.
- `res`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request to begin a run; ignored while `busy`.
- `mode`  in  2  run type, sampled with `start`:
  - 0 = write window, then read window;
  - 1 = consecutive (write then read each address);
  - 2 = write only;
  - 3 = read/check only.
- `start_addr`  in  ADDR_WIDTH  first address, sampled with `start`.
- `count`  in  ADDR_WIDTH+1  words in window, sampled with `start`; 0 means DEPTH; values above DEPTH clamp to DEPTH.
- `seed`  in  WIDTH  pattern seed, sampled with `start`.
- `valid`  out  1  request valid to memory.
- `wr_rd`  out  1  1 = write, 0 = read.
- `addr`  out  ADDR_WIDTH  request address.
- `wdata`  out  WIDTH  write data.
- `rdata`  in  WIDTH  read data from memory.
- `ready`  in  1  memory accepts/completes the current request.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 when the last run had zero mismatches; held until next `start`.
- `err_count`  out  ADDR_WIDTH+1  mismatches in the current/last run; saturates at all-ones.
- `fail_addr`  out  ADDR_WIDTH  address of the first mismatch.
- `fail_data`  out  WIDTH  rdata of the first mismatch.

## Operation
- **Pattern:** expected/written data for address A is `(seed + A) mod 2^WIDTH`. Address arithmetic is modulo DEPTH, so windows wrap from DEPTH-1 to 0.
- **States:** IDLE, WRITE, READ, DONE.
- **IDLE:**
  - `start` captures the inputs.
  - Mode 0, 1 or 2 → WRITE; mode 3 → READ.
  - Clears `err_count`, `pass`, `fail_addr`, `fail_data`.
- **WRITE:**
  - Drives `valid=1`, `wr_rd=1`, `addr`, `wdata`.
  - On handshake (`valid && ready` at an edge):
    - mode 0/2: advance address; after the last word, go to READ (mode 0) or DONE (mode 2);
    - mode 1: go to READ at the same address.
- **READ:**
  - Drives `valid=1`, `wr_rd=0`, `addr`; `wdata` is 0.
  - On handshake, compares `rdata` with the expected pattern and updates the error outputs.
  - Mode 1: after each read, go to WRITE at the next address, or DONE after the last.
  - Mode 0/3: advance; after the last word, go to DONE.
- **DONE:**
  - `done=1` and `pass=(err_count==0)` for one cycle; return to IDLE.
  - `busy` drops on the same edge that enters IDLE.
- **Handshake rules:**
  - `valid`, `wr_rd`, `addr` and `wdata` are registered and held stable until the handshake edge.
  - After a handshake, the next request may be presented the following cycle (back-to-back allowed).
  - A request is never withdrawn once valid is asserted.
- **First failure:** `fail_addr`/`fail_data` latch on the first mismatch only.
- **Outside a run:** `valid=0`, `wr_rd=0`, `addr=0`, `wdata=0`.

## Timing
- **Reset:** `res` high at an edge forces IDLE and clears all outputs to 0 (`valid`, `wr_rd`, `addr`, `wdata`, `busy`, `done`, `pass`, `err_count`, `fail_addr`, `fail_data`).
- **Reset mid-run:** the request is abandoned; `valid` is 0 from the next cycle; no `done` pulse.
- **Start latency:** `start` sampled at edge T → `busy`, `valid` and the first request appear after T (cycle T+1).
- **Read sampling:** `rdata` is sampled at the read handshake edge.
- **Run length with `ready` held high:**
  - mode 0: N writes + N reads occupy 2N cycles; `done` in the cycle after the last handshake;
  - mode 1: 2N cycles, then `done`;
  - mode 2/3: N cycles, then `done`.
- **Backpressure:** each cycle with `ready=0` stalls the run one cycle with no state change.
- **Start while busy:** ignored; no effect on captured parameters.
- **Start in the DONE cycle:** ignored.
- **Simultaneous `start` and `res`:** `res` wins.
- **Saturation:** `err_count` holds at 2^(ADDR_WIDTH+1)-1.

## Test plan
- **Reset:** hold `res` 2 cycles → all outputs 0; `start` during `res` is ignored.
- **Mode 0, single word:** start_addr=15, count=1, seed=8'h10, `ready` tied high, memory model correct →
  - one write addr=15, wdata=8'h1F;
  - one read addr=15;
  - `done` 2 cycles after the first request; `pass=1`; `err_count=0`.
- **Mode 0, wrap:** start_addr=28, count=8 →
  - addresses 28..31, then 0..3, for both writes and reads;
  - `pass=1`;
  - with `ready` toggling 1/0 every cycle, the run takes 32 cycles and signals stay stable across stalls.
- **Mode 1, full depth:** count=0 →
  - alternating W/R for addresses 0..31 (64 handshakes);
  - `done` once; `pass=1`.
- **Mode 3 with corruption:** preload memory with pattern seed=0 except addr 5 = 8'hAA; run seed=0, count=0 →
  - `err_count=1`, `fail_addr=5`, `fail_data=8'hAA`, `pass=0`.
- **Abort:** assert `res` mid-run of mode 2 with `ready=0` →
  - `valid=0` next cycle; no `done`;
  - a new `start` afterwards runs normally.

Source files
------------

// File: rtl/mem_seq_master.sv
// Pattern write / read-back sequencer for a single-port valid/ready memory.
// Data for address A is (seed + A) mod 2^WIDTH; windows wrap modulo DEPTH.
module mem_seq_master #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic [WIDTH-1:0]      seed,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0]      fail_data
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0]         ERR_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0]         CNT_ZERO  = {CW{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [WIDTH-1:0]      DATA_ZERO = {WIDTH{1'b0}};

    localparam logic [1:0] MODE_WR_RD   = 2'd0;
    localparam logic [1:0] MODE_CONSEC  = 2'd1;
    localparam logic [1:0] MODE_RD_ONLY = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0]      s,
                                                 input logic [ADDR_WIDTH-1:0] a);
        return s + WIDTH'(a);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? ADDR_ZERO : a + ADDR_WIDTH'(1);
    endfunction

    function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] c);
        return (c == CNT_ZERO || c > DEPTH_C) ? DEPTH_C : c;
    endfunction

    state_e                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [WIDTH-1:0]      seed_q, seed_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]         len_q, len_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  wr_rd_q, wr_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [CW-1:0]         err_q, err_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [WIDTH-1:0]      fail_data_q, fail_data_d;

    logic                  handshake;
    logic                  last_word;
    logic                  mismatch;
    logic                  run_end;
    logic [ADDR_WIDTH-1:0] addr_next;

    assign handshake = valid_q && ready;
    assign last_word = (idx_q == len_q - CW'(1));
    assign addr_next = addr_inc(addr_q);
    assign mismatch  = (rdata != pattern(seed_q, addr_q));

    // Sequencer: next request, phase changes and error tracking.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        seed_d      = seed_q;
        base_d      = base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        wr_rd_d     = wr_rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        run_end     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    seed_d      = seed;
                    base_d      = start_addr;
                    len_d       = clamp_len(count);
                    idx_d       = CNT_ZERO;
                    busy_d      = 1'b1;
                    valid_d     = 1'b1;
                    addr_d      = start_addr;
                    pass_d      = 1'b0;
                    err_d       = CNT_ZERO;
                    fail_addr_d = ADDR_ZERO;
                    fail_data_d = DATA_ZERO;
                    if (mode == MODE_RD_ONLY) begin
                        state_d = ST_READ;
                        wr_rd_d = 1'b0;
                        wdata_d = DATA_ZERO;
                    end else begin
                        state_d = ST_WRITE;
                        wr_rd_d = 1'b1;
                        wdata_d = pattern(seed, start_addr);
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_WRITE: begin
                if (handshake) begin
                    if (mode_q == MODE_CONSEC) begin
                        state_d = ST_READ;
                        wr_rd_d = 1'b0;
                        wdata_d = DATA_ZERO;
                    end else if (!last_word) begin
                        addr_d  = addr_next;
                        idx_d   = idx_q + CW'(1);
                        wdata_d = pattern(seed_q, addr_next);
                    end else if (mode_q == MODE_WR_RD) begin
                        state_d = ST_READ;
                        addr_d  = base_q;
                        idx_d   = CNT_ZERO;
                        wr_rd_d = 1'b0;
                        wdata_d = DATA_ZERO;
                    end else begin
                        run_end = 1'b1;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (handshake) begin
                    if (mismatch) begin
                        err_d = (err_q == ERR_MAX) ? err_q : err_q + CW'(1);
                        if (err_q == CNT_ZERO) begin
                            fail_addr_d = addr_q;
                            fail_data_d = rdata;
                        end else begin
                            fail_addr_d = fail_addr_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    if (last_word) begin
                        run_end = 1'b1;
                    end else begin
                        addr_d = addr_next;
                        idx_d  = idx_q + CW'(1);
                        if (mode_q == MODE_CONSEC) begin
                            state_d = ST_WRITE;
                            wr_rd_d = 1'b1;
                            wdata_d = pattern(seed_q, addr_next);
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                wr_rd_d = 1'b0;
                addr_d  = ADDR_ZERO;
                wdata_d = DATA_ZERO;
                busy_d  = 1'b0;
            end
        endcase

        // The DONE cycle already presents idle request signals.
        if (run_end) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            wr_rd_d = 1'b0;
            addr_d  = ADDR_ZERO;
            wdata_d = DATA_ZERO;
            done_d  = 1'b1;
            pass_d  = (err_d == CNT_ZERO);
        end else begin
            done_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= ST_IDLE;
            mode_q      <= 2'd0;
            seed_q      <= DATA_ZERO;
            base_q      <= ADDR_ZERO;
            len_q       <= CNT_ZERO;
            idx_q       <= CNT_ZERO;
            valid_q     <= 1'b0;
            wr_rd_q     <= 1'b0;
            addr_q      <= ADDR_ZERO;
            wdata_q     <= DATA_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= CNT_ZERO;
            fail_addr_q <= ADDR_ZERO;
            fail_data_q <= DATA_ZERO;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            base_q      <= base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            wr_rd_q     <= wr_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign valid     = valid_q;
    assign wr_rd     = wr_rd_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_mem_seq_master.sv
// Scoreboard bench for mem_seq_master: a reference model queues the expected
// request stream and run results; a negedge monitor pops and compares them.
module tb_mem_seq_master;

    localparam int W  = 8;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] start_addr = 5'd0;
    logic [AW:0]   count = 6'd0;
    logic [W-1:0]  seed = 8'd0;
    logic          valid, wr_rd, busy, done, pass;
    logic [AW-1:0] addr, fail_addr;
    logic [W-1:0]  wdata, rdata, fail_data;
    logic [AW:0]   err_count;
    logic          ready = 1'b0;

    always #5 clk = ~clk;

    mem_seq_master #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .res(res), .start(start), .mode(mode), .start_addr(start_addr),
        .count(count), .seed(seed), .valid(valid), .wr_rd(wr_rd), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    typedef struct { bit wr; int a; int d; } txn_t;
    typedef struct { bit ps; int errs; int fa; int fd; int cyc; } res_t;

    txn_t exp_txn[$];
    res_t exp_res[$];
    int   checks = 0;
    int   errors = 0;
    int   rmode  = 3;

    logic [W-1:0] mem [D];
    logic [W-1:0] pl_mem [D];
    bit           pl_go = 1'b0;
    int           ref_mem [D];
    int           m_errs, m_fa, m_fd;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    // Memory model: preload or accept writes at the handshake edge.
    always @(posedge clk) begin
        if (pl_go) begin
            for (int i = 0; i < D; i++) mem[i] <= pl_mem[i];
        end else if (valid && ready && wr_rd) begin
            mem[addr] <= wdata;
        end
    end
    assign rdata = (valid && !wr_rd) ? mem[addr] : 8'h00;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            2:       ready = 1'($urandom_range(0, 1));
            default: ready = 1'b0;
        endcase
    end

    // Monitor
    bit            prev_stall = 1'b0;
    bit            prev_done  = 1'b0;
    logic          ps_wr;
    logic [AW-1:0] ps_addr;
    logic [W-1:0]  ps_wdata;
    int            busy_cyc = 0;
    txn_t          mt;
    res_t          mr;

    always @(negedge clk) begin
        if (res) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            busy_cyc   = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(valid), 1);
                chk("stall_wr_rd", 32'(wr_rd), 32'(ps_wr));
                chk("stall_addr", 32'(addr), 32'(ps_addr));
                chk("stall_wdata", 32'(wdata), 32'(ps_wdata));
            end
            if (prev_done) begin
                chk("idle_busy", 32'(busy), 0);
                chk("idle_valid", 32'(valid), 0);
                chk("idle_wr_rd", 32'(wr_rd), 0);
                chk("idle_addr", 32'(addr), 0);
                chk("idle_wdata", 32'(wdata), 0);
                chk("done_one_cycle", 32'(done), 0);
            end
            if (busy) busy_cyc++;
            else busy_cyc = 0;
            if (valid && ready) begin
                if (exp_txn.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    mt = exp_txn.pop_front();
                    chk("req_wr_rd", 32'(wr_rd), 32'(mt.wr));
                    chk("req_addr", 32'(addr), mt.a);
                    chk("req_wdata", 32'(wdata), mt.d);
                end
            end
            prev_stall = valid && !ready;
            ps_wr      = wr_rd;
            ps_addr    = addr;
            ps_wdata   = wdata;
            if (done) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mr = exp_res.pop_front();
                    chk("done_pass", 32'(pass), 32'(mr.ps));
                    chk("done_err_count", 32'(err_count), mr.errs);
                    chk("done_fail_addr", 32'(fail_addr), mr.fa);
                    chk("done_fail_data", 32'(fail_data), mr.fd);
                    chk("done_busy", 32'(busy), 1);
                    chk("done_valid", 32'(valid), 0);
                    if (mr.cyc >= 0) chk("run_cycles", busy_cyc, mr.cyc);
                end
            end
            prev_done = done;
        end
    end

    function automatic void model_wr(input int a, input int sd);
        txn_t t;
        t.wr = 1'b1; t.a = a; t.d = (sd + a) % 256;
        exp_txn.push_back(t);
        ref_mem[a] = t.d;
    endfunction

    function automatic void model_rd(input int a, input int sd);
        txn_t t;
        t.wr = 1'b0; t.a = a; t.d = 0;
        exp_txn.push_back(t);
        if (ref_mem[a] != (sd + a) % 256) begin
            if (m_errs == 0) begin
                m_fa = a;
                m_fd = ref_mem[a];
            end
            m_errs++;
        end
    endfunction

    task automatic preload(input int sd, input int bad_a, input int bad_v);
        for (int i = 0; i < D; i++) begin
            ref_mem[i] = (i == bad_a) ? bad_v : (sd + i) % 256;
            pl_mem[i]  = 8'(ref_mem[i]);
        end
        @(posedge clk); #1 pl_go = 1'b1;
        @(posedge clk); #1 pl_go = 1'b0;
    endtask

    task automatic run(input int m, input int sa, input int cnt, input int sd,
                       input int rm, input bit busy_start, input bit done_start);
        int   n;
        bit   got;
        res_t r;
        n = (cnt == 0 || cnt > D) ? D : cnt;
        m_errs = 0; m_fa = 0; m_fd = 0;
        if (m == 1) begin
            for (int i = 0; i < n; i++) begin
                model_wr((sa + i) % D, sd);
                model_rd((sa + i) % D, sd);
            end
        end else begin
            if (m != 3) for (int i = 0; i < n; i++) model_wr((sa + i) % D, sd);
            if (m != 2) for (int i = 0; i < n; i++) model_rd((sa + i) % D, sd);
        end
        r.ps = (m_errs == 0); r.errs = m_errs; r.fa = m_fa; r.fd = m_fd;
        r.cyc = (rm == 0) ? (((m < 2) ? 2 * n : n) + 1) : -1;
        exp_res.push_back(r);

        rmode = rm;
        @(posedge clk); #1;
        start = 1'b1; mode = m[1:0]; start_addr = sa[AW-1:0]; count = cnt[AW:0]; seed = sd[W-1:0];
        @(posedge clk); #1 start = 1'b0;
        if (busy_start) begin
            @(posedge clk); #1;
            start = 1'b1; mode = ~mode; start_addr = start_addr + 5'd3; count = 6'd7; seed = ~seed;
            @(posedge clk); #1 start = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("done_seen", 32'(got), 1);
        if (!got) begin
            exp_txn.delete();
            exp_res.delete();
        end
        if (done_start && got) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            chk("done_start_busy", 32'(busy), 0);
            chk("done_start_valid", 32'(valid), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with start asserted
        res = 1'b1; start = 1'b1; mode = 2'd2; count = 6'd4; seed = 8'h21;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_wr_rd", 32'(wr_rd), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_fail_addr", 32'(fail_addr), 0);
        chk("rst_fail_data", 32'(fail_data), 0);
        res = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_ignored_busy", 32'(busy), 0);
        chk("rst_start_ignored_valid", 32'(valid), 0);

        preload(0, -1, 0);

        run(0, 15, 1, 8'h10, 0, 1'b0, 1'b0);
        chk("single_pass", 32'(pass), 1);
        chk("single_err_count", 32'(err_count), 0);

        run(0, 28, 8, int'($urandom_range(0, 255)), 1, 1'b0, 1'b0);
        chk("wrap_pass", 32'(pass), 1);

        run(1, 0, 0, 8'h5A, 0, 1'b0, 1'b0);
        chk("consec_pass", 32'(pass), 1);

        preload(0, 5, 8'hAA);
        run(3, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("corrupt_err_count", 32'(err_count), 1);
        chk("corrupt_fail_addr", 32'(fail_addr), 5);
        chk("corrupt_fail_data", 32'(fail_data), 8'hAA);
        chk("corrupt_pass", 32'(pass), 0);

        // Abort a stalled mode-2 run with reset
        rmode = 3;
        @(posedge clk); #1;
        start = 1'b1; mode = 2'd2; start_addr = 5'd3; count = 6'd10; seed = 8'h33;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_valid_before", 32'(valid), 1);
        chk("abort_busy_before", 32'(busy), 1);
        @(posedge clk); #1 res = 1'b1;
        @(posedge clk); #1 res = 1'b0;
        @(negedge clk);
        chk("abort_valid_after", 32'(valid), 0);
        chk("abort_busy_after", 32'(busy), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
        end

        run(2, 3, 10, 8'h33, 0, 1'b1, 1'b1);
        run(0, 30, 6, 8'h33, 2, 1'b0, 1'b0);

        for (int j = 0; j < 20; j++) begin
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 40)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)) * 2, 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        chk("txn_queue_empty", exp_txn.size(), 0);
        chk("res_queue_empty", exp_res.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
